parallel_bus_pollable_memory: RTL

PARALLEL_BUS_POLLABLE_MEMORY -- requirements
Module: parallel_bus_pollable_memory

---
 rtl/parallel_bus_pollable_memory.sv | 221 ++++++++++++++++++++++
 1 files changed

// File: rtl/parallel_bus_pollable_memory.sv
// Pollable word memory behind a narrow handshaked parallel bus: address and data words
// are moved as several bus-width parts, most significant first, with auto-increment.
module parallel_bus_pollable_memory #(
    parameter int BUS_WIDTH            = 8,
    parameter int ADDRESS_TRANSACTIONS = 2,
    parameter int DATA_TRANSACTIONS    = 4,
    parameter int DEPTH_LOG2           = 10
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic [BUS_WIDTH-1:0]  bus_in,
    output logic [BUS_WIDTH-1:0]  bus_out,
    output logic                  bus_oe,
    input  logic                  read,
    input  logic                  register_select,
    input  logic                  enable,
    output logic                  ack,
    output logic                  write_strobe,
    output logic [DEPTH_LOG2-1:0] address
);
    localparam int AW  = ADDRESS_TRANSACTIONS * BUS_WIDTH;
    localparam int DW  = DATA_TRANSACTIONS * BUS_WIDTH;
    localparam int APW = (ADDRESS_TRANSACTIONS > 1) ? $clog2(ADDRESS_TRANSACTIONS) : 1;
    localparam int DPW = (DATA_TRANSACTIONS > 1) ? $clog2(DATA_TRANSACTIONS) : 1;
    localparam logic [APW-1:0] A_LAST = APW'(ADDRESS_TRANSACTIONS - 1);
    localparam logic [DPW-1:0] D_LAST = DPW'(DATA_TRANSACTIONS - 1);

    typedef enum logic [1:0] {IDLE = 2'd0, FETCH = 2'd1, ACK = 2'd2} state_t;

    state_t               state_r, next_state_s;
    logic [BUS_WIDTH-1:0] bus_meta_r, bus_sync_r;
    logic                 rd_meta_r, rd_sync_r, rs_meta_r, rs_sync_r, en_meta_r, en_sync_r;
    logic [AW-1:0]        addr_reg_r, addr_capt_s, addr_inc_s;
    logic [APW-1:0]       addr_part_r, addr_eff_s;
    logic [DPW-1:0]       wr_part_r, rd_part_r, wr_eff_s, rd_eff_s;
    logic                 last_was_addr_r, last_data_read_r, cur_addr_r, cur_read_r;
    logic [DW-1:0]        word_r, word_capt_s, hold_r, hold_word_s, mem_rd_r;
    logic [BUS_WIDTH-1:0] bus_out_r, bus_part_s;
    logic                 ack_r, write_strobe_r;
    logic                 start_addr_s, start_wr_s, start_rd_s, fetch_s, finish_s;
    logic                 commit_s, rd_last_s;
    logic [DW-1:0]        mem_r [2**DEPTH_LOG2];

    function automatic logic [APW-1:0] inc_apart(input logic [APW-1:0] p);
        return (p == A_LAST) ? '0 : p + APW'(1);
    endfunction

    function automatic logic [DPW-1:0] inc_dpart(input logic [DPW-1:0] p);
        return (p == D_LAST) ? '0 : p + DPW'(1);
    endfunction

    // Two-flop synchronisers for all pad inputs
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            bus_meta_r <= '0;
            bus_sync_r <= '0;
            rd_meta_r  <= 1'b0;
            rd_sync_r  <= 1'b0;
            rs_meta_r  <= 1'b0;
            rs_sync_r  <= 1'b0;
            en_meta_r  <= 1'b0;
            en_sync_r  <= 1'b0;
        end else begin
            bus_meta_r <= bus_in;
            bus_sync_r <= bus_meta_r;
            rd_meta_r  <= read;
            rd_sync_r  <= rd_meta_r;
            rs_meta_r  <= register_select;
            rs_sync_r  <= rs_meta_r;
            en_meta_r  <= enable;
            en_sync_r  <= en_meta_r;
        end
    end

    // FSM state register
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_r <= IDLE;
        end else begin
            state_r <= next_state_s;
        end
    end

    // FSM next-state logic; a read of the address register is simply ignored
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            IDLE: begin
                if (start_addr_s || start_wr_s) begin
                    next_state_s = ACK;
                end else if (start_rd_s) begin
                    next_state_s = FETCH;
                end else begin
                    next_state_s = IDLE;
                end
            end
            FETCH:   next_state_s = ACK;
            ACK:     next_state_s = en_sync_r ? ACK : IDLE;
            default: next_state_s = IDLE;
        endcase
    end

    // FSM output decode and datapath steering
    always_comb begin
        start_addr_s = (state_r == IDLE) && en_sync_r && !rd_sync_r && !rs_sync_r;
        start_wr_s   = (state_r == IDLE) && en_sync_r && !rd_sync_r && rs_sync_r;
        start_rd_s   = (state_r == IDLE) && en_sync_r && rd_sync_r && rs_sync_r;
        fetch_s      = (state_r == FETCH);
        finish_s     = (state_r == ACK) && !en_sync_r;
        commit_s     = finish_s && !cur_addr_r && !cur_read_r && (wr_part_r == D_LAST);
        rd_last_s    = finish_s && !cur_addr_r && cur_read_r && (rd_part_r == D_LAST);
        addr_eff_s   = last_was_addr_r ? addr_part_r : '0;
        wr_eff_s     = last_data_read_r ? '0 : wr_part_r;
        rd_eff_s     = last_data_read_r ? rd_part_r : '0;
        hold_word_s  = (rd_part_r == '0) ? mem_rd_r : hold_r;
        bus_part_s   = BUS_WIDTH'(hold_word_s >> (BUS_WIDTH * (DATA_TRANSACTIONS - 1 - int'(rd_part_r))));
        addr_inc_s   = addr_reg_r;
        addr_inc_s[DEPTH_LOG2-1:0] = addr_reg_r[DEPTH_LOG2-1:0] + DEPTH_LOG2'(1);
        addr_capt_s  = addr_reg_r;
        for (int i = 0; i < ADDRESS_TRANSACTIONS; i++) begin
            if (APW'(i) == addr_eff_s) begin
                addr_capt_s[(ADDRESS_TRANSACTIONS-1-i)*BUS_WIDTH +: BUS_WIDTH] = bus_sync_r;
            end else begin
                addr_capt_s[(ADDRESS_TRANSACTIONS-1-i)*BUS_WIDTH +: BUS_WIDTH] =
                    addr_reg_r[(ADDRESS_TRANSACTIONS-1-i)*BUS_WIDTH +: BUS_WIDTH];
            end
        end
        word_capt_s = word_r;
        for (int i = 0; i < DATA_TRANSACTIONS; i++) begin
            if (DPW'(i) == wr_eff_s) begin
                word_capt_s[(DATA_TRANSACTIONS-1-i)*BUS_WIDTH +: BUS_WIDTH] = bus_sync_r;
            end else begin
                word_capt_s[(DATA_TRANSACTIONS-1-i)*BUS_WIDTH +: BUS_WIDTH] =
                    word_r[(DATA_TRANSACTIONS-1-i)*BUS_WIDTH +: BUS_WIDTH];
            end
        end
    end

    // Transfer bookkeeping: part counters, address register, outputs
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            addr_reg_r       <= '0;
            addr_part_r      <= '0;
            wr_part_r        <= '0;
            rd_part_r        <= '0;
            last_was_addr_r  <= 1'b0;
            last_data_read_r <= 1'b0;
            cur_addr_r       <= 1'b0;
            cur_read_r       <= 1'b0;
            word_r           <= '0;
            hold_r           <= '0;
            bus_out_r        <= '0;
            ack_r            <= 1'b0;
            write_strobe_r   <= 1'b0;
        end else begin
            write_strobe_r <= commit_s;
            if (start_addr_s || start_wr_s || start_rd_s) begin
                cur_addr_r <= start_addr_s;
                cur_read_r <= start_rd_s;
            end
            if (start_addr_s || start_wr_s || fetch_s) begin
                ack_r <= 1'b1;
            end else if (finish_s) begin
                ack_r <= 1'b0;
            end
            if (fetch_s) begin
                hold_r    <= hold_word_s;
                bus_out_r <= bus_part_s;
            end
            if (start_wr_s) begin
                word_r <= word_capt_s;
            end
            if (start_addr_s) begin
                addr_reg_r      <= addr_capt_s;
                addr_part_r     <= addr_eff_s;
                wr_part_r       <= '0;
                rd_part_r       <= '0;
                last_was_addr_r <= 1'b1;
            end else if (start_wr_s) begin
                wr_part_r        <= wr_eff_s;
                rd_part_r        <= last_data_read_r ? '0 : rd_part_r;
                last_was_addr_r  <= 1'b0;
                last_data_read_r <= 1'b0;
            end else if (start_rd_s) begin
                rd_part_r        <= rd_eff_s;
                wr_part_r        <= last_data_read_r ? wr_part_r : '0;
                last_was_addr_r  <= 1'b0;
                last_data_read_r <= 1'b1;
            end else if (finish_s) begin
                if (cur_addr_r) begin
                    addr_part_r <= inc_apart(addr_part_r);
                end else if (cur_read_r) begin
                    rd_part_r <= inc_dpart(rd_part_r);
                end else begin
                    wr_part_r <= inc_dpart(wr_part_r);
                end
                if (commit_s || rd_last_s) begin
                    addr_reg_r <= addr_inc_s;
                end
            end
        end
    end

    // Memory write port
    always_ff @(posedge clock) begin
        if (commit_s) begin
            mem_r[addr_reg_r[DEPTH_LOG2-1:0]] <= word_r;
        end
    end

    // Memory read port, one cycle latency, follows the current address continuously
    always_ff @(posedge clock) begin
        mem_rd_r <= mem_r[addr_reg_r[DEPTH_LOG2-1:0]];
    end

    assign bus_out      = bus_out_r;
    assign bus_oe       = rd_sync_r;
    assign ack          = ack_r;
    assign write_strobe = write_strobe_r;
    assign address      = addr_reg_r[DEPTH_LOG2-1:0];
endmodule
